// File: rtl/div_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// div_seq_ctrl_pkg : shared constants and FSM encoding for the divide sequencer
// Revision: 1.0
// ============================================================================
package div_seq_ctrl_pkg;

    localparam int DIV_DATA_W = 16;
    localparam int DIV_Q_ADDR = 1;
    localparam int DIV_R_ADDR = 2;

    typedef logic [2:0] t_div_state;

    localparam t_div_state DIV_IDLE   = 3'd0;
    localparam t_div_state DIV_CHECK  = 3'd1;
    localparam t_div_state DIV_DIVIDE = 3'd2;
    localparam t_div_state DIV_FIXUP  = 3'd3;
    localparam t_div_state DIV_WR_Q   = 3'd4;
    localparam t_div_state DIV_WR_R   = 3'd5;
    localparam t_div_state DIV_DONE   = 3'd6;

endpackage
`default_nettype wire

// File: rtl/div_seq_ctrl_core.sv
`default_nettype none
// ============================================================================
// div_core : iterative unsigned restoring divider, one quotient bit per cycle
// Revision: 1.0
// ============================================================================
module div_core #(
    parameter int DATA_W = 16
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              Start,
    input  logic [DATA_W-1:0] Dvd,
    input  logic [DATA_W-1:0] Dvs,
    output logic              Done,
    output logic [DATA_W-1:0] Quot,
    output logic [DATA_W-1:0] Rem
);

    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W:0]   rem_r;
    logic [DATA_W-1:0] quo_r;
    logic [DATA_W-1:0] dvs_r;
    logic [CNT_W-1:0]  iter_cnt;
    logic              running;
    logic [DATA_W+1:0] shifted;
    logic [DATA_W+1:0] trial;

    assign shifted = {rem_r, quo_r[DATA_W-1]};
    assign trial   = shifted - {2'b00, dvs_r};

    // High during the final iteration so the caller leaves its wait state on
    // the same edge that the last quotient bit lands.
    assign Done = running && (iter_cnt == CNT_W'(DATA_W - 1));
    assign Quot = quo_r;
    assign Rem  = rem_r[DATA_W-1:0];

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            rem_r    <= '0;
            quo_r    <= '0;
            dvs_r    <= '0;
            iter_cnt <= '0;
            running  <= 1'b0;
        end else if (Start) begin
            rem_r    <= '0;
            quo_r    <= Dvd;
            dvs_r    <= Dvs;
            iter_cnt <= '0;
            running  <= 1'b1;
        end else if (running) begin
            if (trial[DATA_W+1]) begin
                rem_r <= shifted[DATA_W:0];
                quo_r <= {quo_r[DATA_W-2:0], 1'b0};
            end else begin
                rem_r <= trial[DATA_W:0];
                quo_r <= {quo_r[DATA_W-2:0], 1'b1};
            end
            iter_cnt <= iter_cnt + CNT_W'(1);
            if (Done) begin
                running <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/div_seq_ctrl.sv
`default_nettype none
// ============================================================================
// div_seq_ctrl : replaces the repeated-subtraction loop with a hardware divide
//                and writes the loop's final architectural state back.
// Revision: 1.0
// ============================================================================
module div_seq_ctrl
    import div_seq_ctrl_pkg::*;
#(
    parameter int DATA_W = DIV_DATA_W,
    parameter int Q_ADDR = DIV_Q_ADDR,
    parameter int R_ADDR = DIV_R_ADDR
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              StartDiv102,
    input  logic [DATA_W-1:0] Divident,
    input  logic [DATA_W-1:0] Divisor,
    input  logic [DATA_W-1:0] LoopAddr,
    input  logic [DATA_W-1:0] PcAfterLoop,
    input  logic              MemGnt,
    output logic              Stall,
    output logic              Busy,
    output logic              MemWrEn,
    output logic [DATA_W-1:0] MemWrAddr,
    output logic [DATA_W-1:0] MemWrData,
    output logic              DWrEn,
    output logic [DATA_W-1:0] DWrData,
    output logic              AWrEn,
    output logic [DATA_W-1:0] AWrData,
    output logic              PcRedirect,
    output logic [DATA_W-1:0] PcRedirectVal,
    output logic              Fallback
);

    t_div_state        state;
    t_div_state        state_nxt;
    logic [DATA_W-1:0] dvd;
    logic [DATA_W-1:0] dvs;
    logic [DATA_W-1:0] loop_addr;
    logic [DATA_W-1:0] pc_after;
    logic [DATA_W-1:0] r_res;
    logic              core_start;
    logic              core_done;
    logic [DATA_W-1:0] core_quot;
    logic [DATA_W-1:0] core_rem;
    logic [DATA_W-1:0] fix_q;
    logic [DATA_W-1:0] fix_r;
    logic              start_ok;

    // Non-positive divisors never terminate in software; non-positive
    // dividends can wrap positive, so both are left to the software loop.
    function automatic logic operands_ok(input logic [DATA_W-1:0] a,
                                         input logic [DATA_W-1:0] b);
        return !a[DATA_W-1] && (|a) && !b[DATA_W-1] && (|b);
    endfunction

    assign start_ok   = (state == DIV_IDLE) && StartDiv102;
    assign core_start = (state == DIV_CHECK) && operands_ok(dvd, dvs);
    assign MemWrEn    = (state == DIV_WR_Q) || (state == DIV_WR_R);

    // The loop runs one extra iteration whenever the division is inexact,
    // leaving a non-positive residue.
    always_comb begin
        fix_q = core_quot;
        fix_r = '0;
        if (core_rem != '0) begin
            fix_q = core_quot + DATA_W'(1);
            fix_r = core_rem - dvs;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DIV_IDLE:   if (StartDiv102) state_nxt = DIV_CHECK;
            DIV_CHECK:  state_nxt = operands_ok(dvd, dvs) ? DIV_DIVIDE : DIV_IDLE;
            DIV_DIVIDE: if (core_done) state_nxt = DIV_FIXUP;
            DIV_FIXUP:  state_nxt = DIV_WR_Q;
            DIV_WR_Q:   if (MemGnt) state_nxt = DIV_WR_R;
            DIV_WR_R:   if (MemGnt) state_nxt = DIV_DONE;
            DIV_DONE:   state_nxt = DIV_IDLE;
            default:    state_nxt = DIV_IDLE;
        endcase
    end

    div_core #(
        .DATA_W (DATA_W)
    ) u_div_core (
        .Clk    (Clk),
        .ResetN (ResetN),
        .Start  (core_start),
        .Dvd    (dvd),
        .Dvs    (dvs),
        .Done   (core_done),
        .Quot   (core_quot),
        .Rem    (core_rem)
    );

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state         <= DIV_IDLE;
            dvd           <= '0;
            dvs           <= '0;
            loop_addr     <= '0;
            pc_after      <= '0;
            r_res         <= '0;
            Stall         <= 1'b0;
            Busy          <= 1'b0;
            Fallback      <= 1'b0;
            MemWrAddr     <= '0;
            MemWrData     <= '0;
            DWrEn         <= 1'b0;
            DWrData       <= '0;
            AWrEn         <= 1'b0;
            AWrData       <= '0;
            PcRedirect    <= 1'b0;
            PcRedirectVal <= '0;
        end else begin
            state    <= state_nxt;
            Stall    <= (state_nxt != DIV_IDLE);
            Busy     <= (state_nxt != DIV_IDLE);
            Fallback <= start_ok && !operands_ok(Divident, Divisor);

            if (start_ok) begin
                dvd       <= Divident;
                dvs       <= Divisor;
                loop_addr <= LoopAddr;
                pc_after  <= PcAfterLoop;
            end

            case (state)
                DIV_FIXUP: begin
                    MemWrAddr <= DATA_W'(Q_ADDR);
                    MemWrData <= fix_q;
                    r_res     <= fix_r;
                end
                DIV_WR_Q: begin
                    if (MemGnt) begin
                        MemWrAddr <= DATA_W'(R_ADDR);
                        MemWrData <= r_res;
                        DWrEn     <= 1'b1;
                        DWrData   <= r_res;
                    end
                end
                DIV_WR_R: begin
                    if (MemGnt) begin
                        MemWrAddr     <= '0;
                        MemWrData     <= '0;
                        DWrEn         <= 1'b0;
                        DWrData       <= '0;
                        AWrEn         <= 1'b1;
                        AWrData       <= loop_addr;
                        PcRedirect    <= 1'b1;
                        PcRedirectVal <= pc_after;
                    end
                end
                DIV_DONE: begin
                    AWrEn         <= 1'b0;
                    AWrData       <= '0;
                    PcRedirect    <= 1'b0;
                    PcRedirectVal <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
